// File: rtl/lcd_frame_sequencer.sv
// Full-frame RGB565 refresh over a 16-bit 8080 write bus.
// Optional LCD_BORDER_EN: border pixels are written as 0xFF0F with no fetch.
module lcd_frame_sequencer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int WR_LOW     = 1,
  parameter int WR_HIGH    = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pix_req,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic        pix_ack,
  input  logic [15:0] pix_data,
  output logic        frame,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] lcd_dq,
  output logic        lcd_dq_oe,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_cs_n
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, FETCH, WRITE, GAP
  } state_t;

  localparam int WORD_LEN = WR_LOW + WR_HIGH;
  // The frame_done cycle is itself a gap cycle, so the gap is never empty
  localparam int GAP_LEN  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam logic [15:0] H_MAX = 16'(H_RES - 1);
  localparam logic [15:0] V_MAX = 16'(V_RES - 1);
  localparam logic [8:0]  X_MAX = 9'(H_RES - 1);
  localparam logic [8:0]  Y_MAX = 9'(V_RES - 1);

  state_t      state_q, state_d, pix_state;
  logic [15:0] cnt_q;
  logic [3:0]  word_q;
  logic [31:0] gap_q;
  logic [8:0]  x_q, y_q;
  logic [8:0]  x_nx, y_nx;
  logic [15:0] pix_q;
  logic [15:0] pre_dq;
  logic        pre_rs;
  logic        word_end, last_word, last_pix;
  logic        gap_end, next_border;

  assign word_end  = cnt_q == 16'(WORD_LEN - 1);
  assign last_word = word_q == 4'd10;
  assign last_pix  = (x_q == X_MAX) && (y_q == Y_MAX);
  assign gap_end   = gap_q == 32'(GAP_LEN - 1);

  // Coordinates of the pixel that follows the current word
  always_comb begin
    x_nx = 9'd0;
    y_nx = 9'd0;
    if (state_q == WRITE) begin
      x_nx = (x_q == X_MAX) ? 9'd0 : x_q + 9'd1;
      y_nx = (x_q == X_MAX) ? y_q + 9'd1 : y_q;
    end
  end

`ifdef LCD_BORDER_EN
  assign next_border = (x_nx == 9'd0) || (x_nx == X_MAX) ||
                       (y_nx == 9'd0) || (y_nx == Y_MAX);
`else
  assign next_border = 1'b0;
`endif

  assign pix_state = next_border ? WRITE : FETCH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = PREAMBLE;
      PREAMBLE: if (word_end && last_word)
                  state_d = pix_state;
      FETCH:    if (pix_ack) state_d = WRITE;
      WRITE:    if (word_end)
                  state_d = last_pix ? GAP : pix_state;
      GAP:      if (gap_end)
                  state_d = en ? PREAMBLE : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      gap_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pix_q  <= '0;
    end else begin
      if ((state_q == PREAMBLE || state_q == WRITE) && !word_end)
        cnt_q <= cnt_q + 16'd1;
      else
        cnt_q <= '0;

      if (state_q != PREAMBLE)
        word_q <= '0;
      else if (word_end)
        word_q <= word_q + 4'd1;

      if (state_q == GAP) gap_q <= gap_q + 32'd1;
      else                gap_q <= '0;

      if (state_q == WRITE && word_end) begin
        x_q <= last_pix ? 9'd0 : x_nx;
        y_q <= last_pix ? 9'd0 : y_nx;
      end

      if (state_q == FETCH && pix_ack)
        pix_q <= pix_data;
`ifdef LCD_BORDER_EN
      else if (word_end && next_border && state_d == WRITE)
        pix_q <= 16'hFF0F;
`endif
    end
  end

  always_comb begin
    pre_dq = 16'h0000;
    pre_rs = 1'b1;
    unique case (word_q)
      4'd0:    begin pre_dq = 16'h002A; pre_rs = 1'b0; end
      4'd3:    pre_dq = {8'h00, H_MAX[15:8]};
      4'd4:    pre_dq = {8'h00, H_MAX[7:0]};
      4'd5:    begin pre_dq = 16'h002B; pre_rs = 1'b0; end
      4'd8:    pre_dq = {8'h00, V_MAX[15:8]};
      4'd9:    pre_dq = {8'h00, V_MAX[7:0]};
      4'd10:   begin pre_dq = 16'h002C; pre_rs = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    pix_req    = 1'b0;
    frame      = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    lcd_dq     = 16'h0000;
    lcd_dq_oe  = 1'b0;
    lcd_rs     = 1'b1;
    lcd_wr_n   = 1'b1;
    lcd_cs_n   = 1'b1;
    unique case (state_q)
      IDLE: ;
      PREAMBLE: begin
        busy      = 1'b1;
        lcd_dq_oe = 1'b1;
        lcd_cs_n  = 1'b0;
        frame     = (word_q == 4'd0) && (cnt_q == 16'd0);
        lcd_dq    = pre_dq;
        lcd_rs    = pre_rs;
        lcd_wr_n  = cnt_q >= 16'(WR_LOW);
      end
      FETCH: begin
        busy      = 1'b1;
        lcd_dq_oe = 1'b1;
        lcd_cs_n  = 1'b0;
        pix_req   = 1'b1;
        lcd_dq    = pix_q;
      end
      WRITE: begin
        busy      = 1'b1;
        lcd_dq_oe = 1'b1;
        lcd_cs_n  = 1'b0;
        lcd_dq    = pix_q;
        lcd_wr_n  = cnt_q >= 16'(WR_LOW);
      end
      GAP:     frame_done = gap_q == 32'd0;
      default: ;
    endcase
  end

  assign pix_x = x_q;
  assign pix_y = y_q;

endmodule
